// File: rtl/rv_multicycle_mdu.sv
// rv_multicycle_mdu: iterative RV M-extension multiply/divide unit.
// Multiply is unsigned shift-add and divide is restoring division. Both retire
// UNROLL bits per CALC cycle and work on operand magnitudes; signs are applied
// in FIXUP. Defining MDU_FAST_MUL_EN replaces the iterative multiply with a
// single-cycle signed (XLEN+1)x(XLEN+1) multiplier.

module rv_multicycle_mdu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned    N        = XLEN / UNROLL;
    localparam int unsigned    CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST     = CW'(N - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              sa_q;
    logic              sb_q;
    logic              byp_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    // Request decode
    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   byp_val;

    // Iteration datapath
    logic [2*XLEN-1:0] acc_n;
    logic [XLEN-1:0]   a_n;
    logic [XLEN-1:0]   b_n;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic [XLEN:0]     sum;
    logic [XLEN-1:0]   addend;

    // Sign fix-up
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remd;
    logic [XLEN-1:0]   fix_val;

    assign in_ready = rst & ena & (state == IDLE);

    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign neg_a    = a_signed & rs1_data[XLEN-1];
    assign neg_b    = b_signed & rs2_data[XLEN-1];
    assign mag_a    = neg_a ? -rs1_data : rs1_data;
    assign mag_b    = neg_b ? -rs2_data : rs2_data;
    assign div_zero = funct3[2] && (rs2_data == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (rs1_data == MOST_NEG) && (rs2_data == '1);

    // Special-case results: divide-by-zero first, then signed overflow
    always_comb begin
        byp_val = '0;
        if (div_zero) begin
            byp_val = funct3[1] ? rs1_data : '1;
        end else if (div_ovf) begin
            byp_val = funct3[1] ? '0 : MOST_NEG;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0] fast_a;
    logic signed [XLEN:0] fast_b;
    logic [2*XLEN-1:0]    fast_prod;

    assign fast_a    = {neg_a, rs1_data};
    assign fast_b    = {neg_b, rs2_data};
    assign fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
`endif

    // UNROLL steps of shift-add multiply or restoring divide on the magnitudes.
    // Multiply: acc fills from the top with product bits, b shifts out LSB-first.
    // Divide: acc = {remainder, quotient}, dividend bits shift out of a MSB-first.
    always_comb begin
        acc_n  = acc_q;
        a_n    = a_q;
        b_n    = b_q;
        trial  = '0;
        diff   = '0;
        sum    = '0;
        addend = '0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                trial = {acc_n[2*XLEN-1:XLEN], a_n[XLEN-1]};
                diff  = trial - {1'b0, b_n};
                a_n   = a_n << 1;
                if (!diff[XLEN]) begin
                    acc_n = {diff[XLEN-1:0], acc_n[XLEN-2:0], 1'b1};
                end else begin
                    acc_n = {trial[XLEN-1:0], acc_n[XLEN-2:0], 1'b0};
                end
            end else begin
                addend = b_n[0] ? a_n : '0;
                sum    = {1'b0, acc_n[2*XLEN-1:XLEN]} + {1'b0, addend};
                acc_n  = {sum, acc_n[XLEN-1:1]};
                b_n    = b_n >> 1;
            end
        end
    end

    // Apply operand signs and pick the result half or quotient/remainder
    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quot = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remd = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (byp_q) begin
            fix_val = acc_q[XLEN-1:0];
        end else if (op_q[2]) begin
            fix_val = op_q[1] ? remd : quot;
        end else if (op_q[1:0] == 2'b00) begin
            fix_val = prod[XLEN-1:0];
        end else begin
            fix_val = prod[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers; ena=0 freezes everything, kill wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            byp_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else if (ena) begin
            if (kill) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                cnt_q     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            op_q  <= funct3;
                            cnt_q <= '0;
                            sa_q  <= neg_a;
                            sb_q  <= neg_b;
                            a_q   <= mag_a;
                            b_q   <= mag_b;
                            if (div_zero || div_ovf) begin
                                // Final value parked in acc; FIXUP passes it through
                                byp_q <= 1'b1;
                                acc_q <= {{XLEN{1'b0}}, byp_val};
                                state <= FIXUP;
                            end
`ifdef MDU_FAST_MUL_EN
                            else if (!funct3[2]) begin
                                // Product is already signed; suppress FIXUP negation
                                byp_q <= 1'b0;
                                acc_q <= fast_prod;
                                sa_q  <= 1'b0;
                                sb_q  <= 1'b0;
                                state <= FIXUP;
                            end
`endif
                            else begin
                                byp_q <= 1'b0;
                                acc_q <= '0;
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc_q <= acc_n;
                        a_q   <= a_n;
                        b_q   <= b_n;
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            state <= FIXUP;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    FIXUP: begin
                        result    <= fix_val;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                    DONE: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv_multicycle_mdu.sv
// Scoreboard bench for rv_multicycle_mdu: dut0 is XLEN=32/UNROLL=1,
// dut1 is XLEN=32/UNROLL=4. Stimulus pushes expected result and latency,
// the monitor pops on each rising out_valid.

module tb_rv_multicycle_mdu;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT0 = 2;
    localparam int MUL_LAT1 = 2;
`else
    localparam int MUL_LAT0 = 34;
    localparam int MUL_LAT1 = 10;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena  [2];
    logic        kill [2];
    logic        iv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [2:0]  f3   [2];
    logic [31:0] r1   [2];
    logic [31:0] r2   [2];
    logic [31:0] res  [2];
    bit          ov_prev [2];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];

    rv_multicycle_mdu #(.XLEN(32), .UNROLL(1)) dut0 (
        .clk(clk), .rst(rst), .ena(ena[0]), .kill(kill[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .funct3(f3[0]),
        .rs1_data(r1[0]), .rs2_data(r2[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0])
    );

    rv_multicycle_mdu #(.XLEN(32), .UNROLL(4)) dut1 (
        .clk(clk), .rst(rst), .ena(ena[1]), .kill(kill[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .funct3(f3[1]),
        .rs1_data(r1[1]), .rs2_data(r2[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive a request, wait for the handshake, then record the expectation
    task automatic issue(input int d, input string nm, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el, input bit push);
        bit   ok = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        iv[d] = 1'b1;
        f3[d] = f;
        r1[d] = a;
        r2[d] = b;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (ir[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            if (push) begin
                e.res     = er;
                e.lat     = el;
                e.acc_cyc = cyc;
                e.nm      = nm;
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            @(posedge clk); #1;
        end else begin
            total++;
            bad++;
            $display("FAIL %s_accept: got in_ready=0 want 1 within 200 cycles", nm);
        end
        iv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((((d == 0) ? q0.size() : q1.size()) == 0) && !ov[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_dut%0d: got pending results want none", d);
        end
    endtask

    // Monitor: one comparison of result and latency per rising out_valid
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ov[d] && !ov_prev[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid_dut%0d: got result %h want no output", d, res[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk(e.nm, res[d], e.res);
                    chk({e.nm, "_lat"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
                end
            end
            ov_prev[d] = ov[d];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "timeout");
    end

    initial begin
        int nrdy;
        int cnt;
        bit seen;
        for (int d = 0; d < 2; d++) begin
            ena[d]     = 1'b1;
            kill[d]    = 1'b0;
            iv[d]      = 1'b0;
            ordy[d]    = 1'b1;
            f3[d]      = 3'b000;
            r1[d]      = '0;
            r2[d]      = '0;
            ov_prev[d] = 1'b0;
        end
        rst = 1'b0;
        #12;
        chk("reset_in_ready", {31'b0, ir[0]}, 32'd0);
        chk("reset_out_valid", {31'b0, ov[0]}, 32'd0);
        chk("reset_result", res[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Multiply on dut0 with in_ready watched while busy
        issue(0, "mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT0, 1);
        nrdy = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                seen = 1'b1;
                break;
            end
            if (ir[0]) nrdy++;
        end
        chk("mul_busy_in_ready", 32'(nrdy), 32'd0);
        chk("mul_done_seen", {31'b0, seen}, 32'd1);
        issue(0, "mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT0, 1);
        issue(0, "mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT0, 1);
        issue(0, "mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT0, 1);
        issue(0, "div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1);
        issue(0, "rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1);
        issue(0, "divu",   3'b101, 32'd100, 32'd7, 32'd14, 34, 1);
        issue(0, "remu",   3'b111, 32'd100, 32'd7, 32'd2, 34, 1);
        issue(0, "div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1);
        issue(0, "remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 2, 1);
        issue(0, "div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1);
        issue(0, "rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1);
        drain(0);

        // Same ops with four bits retired per cycle
        issue(1, "u4_mul",  3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT1, 1);
        issue(1, "u4_div",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10, 1);
        issue(1, "u4_rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 10, 1);
        issue(1, "u4_divu", 3'b101, 32'd100, 32'd7, 32'd14, 10, 1);
        issue(1, "u4_remu", 3'b111, 32'd100, 32'd7, 32'd2, 10, 1);
        drain(1);

        // Backpressure in DONE
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        issue(0, "bp_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_done_seen", {31'b0, seen}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, ov[0]}, 32'd1);
            chk("bp_hold_result", res[0], 32'd14);
            chk("bp_hold_in_ready", {31'b0, ir[0]}, 32'd0);
        end
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'b0, ov[0]}, 32'd0);
        chk("bp_release_in_ready", {31'b0, ir[0]}, 32'd1);

        // ena=0 while idle blocks acceptance
        @(posedge clk); #1;
        ena[0] = 1'b0;
        @(negedge clk);
        chk("ena_idle_in_ready", {31'b0, ir[0]}, 32'd0);
        @(posedge clk); #1;
        ena[0] = 1'b1;

        // Kill during CALC
        issue(0, "kill_mul", 3'b000, 32'd5, 32'd6, 32'd0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        kill[0] = 1'b1;
        @(posedge clk); #1;
        kill[0] = 1'b0;
        @(negedge clk);
        chk("kill_out_valid", {31'b0, ov[0]}, 32'd0);
        chk("kill_in_ready", {31'b0, ir[0]}, 32'd1);
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (ov[0]) cnt++;
        end
        chk("kill_no_output", 32'(cnt), 32'd0);

        // Asynchronous reset mid-CALC
        issue(0, "rst_div", 3'b100, 32'd1000, 32'd3, 32'd0, 0, 0);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_in_ready", {31'b0, ir[0]}, 32'd0);
        chk("rst_mid_out_valid", {31'b0, ov[0]}, 32'd0);
        chk("rst_mid_result", res[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (ov[0]) cnt++;
        end
        chk("rst_no_output", 32'(cnt), 32'd0);

        // ena=0 for 10 cycles during CALC stretches latency by 10
        issue(0, "ena_div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 44, 1);
        repeat (5) @(posedge clk);
        #1;
        ena[0] = 1'b0;
        nrdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ir[0] || ov[0]) nrdy++;
            @(posedge clk);
        end
        #1;
        ena[0] = 1'b1;
        chk("ena_frozen_outputs", 32'(nrdy), 32'd0);

        drain(0);
        drain(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
